// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among num_req level-held requesters,
// with a watchdog that releases the port when memory never responds.
module mem_port_arbiter #(
  parameter int num_req        = 2,
  parameter int addr_width     = 64,
  parameter int data_width     = 64,
  parameter int timeout_cycles = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [num_req-1:0]               req_read_i,
  input  logic [num_req-1:0]               req_write_i,
  input  logic [num_req*addr_width-1:0]    req_addr_i,
  input  logic [num_req*data_width-1:0]    req_wdata_i,
  output logic [num_req-1:0]               req_resp_o,
  output logic [data_width-1:0]            req_rdata_o,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [addr_width-1:0]            mem_addr,
  output logic [data_width-1:0]            mem_wdata,
  input  logic [data_width-1:0]            mem_rdata,
  input  logic                             mem_resp,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int IW = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int WW = $clog2(timeout_cycles + 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(timeout_cycles - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(num_req - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]     last_idx_q, last_idx_d;
  logic [WW-1:0]     wd_cnt_q, wd_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [num_req-1:0] pending;
  logic               any_pending;
  logic               gnt_pending;
  logic [IW-1:0]      sel_idx, hi_idx, lo_idx;
  logic               found_hi, found_lo;

  assign pending     = req_read_i | req_write_i;
  assign any_pending = |pending;
  assign gnt_pending = pending[gnt_idx_q];

  // Prefer the first pending index above last_idx, else wrap to the first at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < num_req; k++) begin
      if (pending[k] && (k > int'(last_idx_q)) && !found_hi) begin
        found_hi = 1'b1;
        hi_idx   = IW'(k);
      end
      if (pending[k] && (k <= int'(last_idx_q)) && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = IW'(k);
      end
    end
    sel_idx = found_hi ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_idx_q     <= '0;
      last_idx_q    <= IDX_LAST;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_idx_q     <= gnt_idx_d;
      last_idx_q    <= last_idx_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_idx_d     = gnt_idx_q;
    last_idx_d    = last_idx_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          gnt_idx_d = sel_idx;
          wd_cnt_d  = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        // A response on the terminal-count cycle still completes normally.
        if (mem_resp || !gnt_pending) begin
          last_idx_d = gnt_idx_q;
          state_d    = IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          last_idx_d    = gnt_idx_q;
          state_d       = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    req_resp_o = '0;
    busy       = (state_q == GRANT);
    if (state_q == GRANT) begin
      mem_addr              = req_addr_i[int'(gnt_idx_q)*addr_width +: addr_width];
      mem_wdata             = req_wdata_i[int'(gnt_idx_q)*data_width +: data_width];
      mem_write             = req_write_i[gnt_idx_q];
      mem_read              = req_read_i[gnt_idx_q] & ~req_write_i[gnt_idx_q];
      req_resp_o[gnt_idx_q] = mem_resp;
    end
  end

  assign req_rdata_o = mem_rdata;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: immediate-assertion checks plus a response scoreboard.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_read_i, req_write_i;
  logic [NR*AW-1:0]   req_addr_i;
  logic [NR*DW-1:0]   req_wdata_i;
  logic [NR-1:0]      req_resp_o;
  logic [DW-1:0]      req_rdata_o;
  logic               mem_read, mem_write;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;
  logic               mem_resp;
  logic               busy, timeout_err;

  typedef struct {
    int          idx;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  mem_port_arbiter #(
    .num_req(NR), .addr_width(AW), .data_width(DW), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read_i(req_read_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_resp_o(req_resp_o), .req_rdata_o(req_rdata_o),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [63:0] d);
    exp_t e;
    e.idx   = idx;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response pulse must match the oldest expected completion.
  always @(negedge clk) begin
    #2;
    if (!rst && req_resp_o != '0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_resp", 64'(req_resp_o), 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_resp_onehot", 64'(req_resp_o), 64'(1) << e.idx);
        chk("sb_rdata", req_rdata_o, e.rdata);
      end
    end
  end

  initial begin
    int strobes;
    int exp_g;

    rst         = 1'b1;
    req_read_i  = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    mem_rdata   = '0;
    mem_resp    = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_read", 64'(mem_read), 0);
    chk("rst_write", 64'(mem_write), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_resp", 64'(req_resp_o), 0);
    chk("rst_err", 64'(timeout_err), 0);
    rst = 1'b0;

    // Single requester 1 write, response 3 cycles after the strobe.
    @(negedge clk);
    req_write_i             = 2'b10;
    req_addr_i[AW +: AW]    = 64'h40;
    req_wdata_i[DW +: DW]   = 64'hDEAD;
    #1 chk("t1_no_strobe_yet", 64'(mem_write), 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin
        mem_resp = 1'b1;
        push(1, mem_rdata);
      end
      #1;
      chk("t1_write", 64'(mem_write), 1);
      chk("t1_addr", mem_addr, 64'h40);
      chk("t1_wdata", mem_wdata, 64'hDEAD);
      chk("t1_resp", 64'(req_resp_o), (c == 4) ? 64'h2 : 64'h0);
    end
    @(negedge clk);
    mem_resp    = 1'b0;
    req_write_i = '0;
    #1 chk("t1_idle", 64'(busy), 0);

    // Round robin with both requesters held and 1-cycle responses.
    req_addr_i[0 +: AW]  = 64'h100;
    req_addr_i[AW +: AW] = 64'h200;
    req_read_i           = 2'b11;
    exp_g                = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        mem_rdata = 64'h1000 + 64'(c);
        mem_resp  = 1'b1;
        push(exp_g, mem_rdata);
        #1;
        chk("rr_busy", 64'(busy), 1);
        chk("rr_addr", mem_addr, (exp_g == 1) ? 64'h200 : 64'h100);
        exp_g = exp_g ^ 1;
      end else begin
        mem_resp = 1'b0;
        #1 chk("rr_gap", 64'(mem_read), 0);
      end
    end
    req_read_i = '0;

    // Read and write together: write wins; then a plain read with rdata.
    req_read_i  = 2'b01;
    req_write_i = 2'b01;
    @(negedge clk);
    mem_resp = 1'b1;
    push(0, mem_rdata);
    #1;
    chk("mix_write", 64'(mem_write), 1);
    chk("mix_read", 64'(mem_read), 0);
    @(negedge clk);
    mem_resp    = 1'b0;
    req_write_i = '0;
    #1 chk("mix_idle", 64'(busy), 0);
    @(negedge clk);
    mem_rdata = 64'h1234;
    mem_resp  = 1'b1;
    push(0, 64'h1234);
    #1;
    chk("rd_read", 64'(mem_read), 1);
    chk("rd_write", 64'(mem_write), 0);
    chk("rd_rdata", req_rdata_o, 64'h1234);
    @(negedge clk);
    mem_resp   = 1'b0;
    req_read_i = '0;
    mem_rdata  = '0;

    // Watchdog: requester 0 never answered, requester 1 waiting behind it.
    req_read_i = 2'b01;
    strobes    = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (busy && mem_read && mem_addr == 64'h100) begin
        strobes++;
        if (strobes == 1) req_read_i[1] = 1'b1;
        chk("wd_err_low", 64'(timeout_err), 0);
      end else begin
        break;
      end
    end
    chk("wd_strobes", 64'(strobes), 64'(TO));
    chk("wd_idle", 64'(busy), 0);
    chk("wd_err", 64'(timeout_err), 1);
    req_read_i[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("wd_next_busy", 64'(busy), 1);
    chk("wd_next_addr", mem_addr, 64'h200);
    mem_resp = 1'b1;
    push(1, mem_rdata);
    #1 chk("wd_next_resp", 64'(req_resp_o), 64'h2);
    @(negedge clk);
    mem_resp   = 1'b0;
    req_read_i = '0;
    #1 chk("wd_err_sticky", 64'(timeout_err), 1);

    // Abort: requester 0 drops mid-grant; last_idx moves so requester 1 wins next.
    req_read_i = 2'b01;
    @(negedge clk);
    #1 chk("ab_strobe", 64'(mem_read), 1);
    req_read_i = '0;
    @(negedge clk);
    #1;
    chk("ab_idle", 64'(busy), 0);
    chk("ab_read", 64'(mem_read), 0);
    req_read_i = 2'b11;
    @(negedge clk);
    #1 chk("ab_next_addr", mem_addr, 64'h200);
    mem_resp = 1'b1;
    push(1, mem_rdata);
    @(negedge clk);
    mem_resp   = 1'b0;
    req_read_i = '0;

    // Asynchronous reset mid-grant, then priority restarts at requester 0.
    req_write_i = 2'b10;
    @(negedge clk);
    #1 chk("rs_write_before", 64'(mem_write), 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_write", 64'(mem_write), 0);
    chk("rs_busy", 64'(busy), 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_resp", 64'(req_resp_o), 0);
    chk("rs_err", 64'(timeout_err), 0);
    @(negedge clk);
    rst         = 1'b0;
    req_write_i = 2'b11;
    @(negedge clk);
    #1;
    chk("rs_first_addr", mem_addr, 64'h100);
    chk("rs_first_write", 64'(mem_write), 1);
    mem_resp = 1'b1;
    push(0, mem_rdata);
    @(negedge clk);
    mem_resp    = 1'b0;
    req_write_i = '0;

    // Response on the terminal-count cycle is a normal completion.
    req_read_i = 2'b01;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c == TO) begin
        mem_resp = 1'b1;
        push(0, mem_rdata);
      end
      #1 chk("tc_read", 64'(mem_read), 1);
    end
    @(negedge clk);
    mem_resp   = 1'b0;
    req_read_i = '0;
    #1;
    chk("tc_idle", 64'(busy), 0);
    chk("tc_err", 64'(timeout_err), 0);

    repeat (2) @(negedge clk);
    #3 chk("sb_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
